fp_mul_issue_ctrl: RTL

- Handshake front/back end for the pipelined FP32 multiplier.
- The multiplier core has no valid, no reset and no stall. This block supplies all three.
- It issues operand pairs into the core and tracks each one through the core's fixed latency with a valid/tag shift register.
- It overrides IEEE special cases that the core does not handle, and buffers results in a credit-protected output FIFO so that no result is ever dropped under backpressure.

---
 rtl/fp_mul_issue_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fp_mul_issue_ctrl.sv
// Issue/collect wrapper around a free-running FP32 multiplier core.
// Operands are latched onto mul_a/mul_b on accept. A valid/class/sign tag
// follows them through the core latency. Results land in a credit-protected
// FIFO with IEEE special-case overrides applied on the way in.
module fp_mul_issue_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_c,
  output logic [2:0]  out_flags,
  output logic        busy
);

  localparam int PW = $clog2(DEPTH);
  // Credits bound both counts by DEPTH, so their sum fits in this width.
  localparam int CW = $clog2(2 * DEPTH + 1);

  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

  // Special-case class of an operand pair; denormals count as zero.
  function automatic cls_t classify(input logic [31:0] a, input logic [31:0] b);
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return CLS_NAN;
    else if (a_inf || b_inf) return CLS_INF;
    else if (a_zero || b_zero) return CLS_ZERO;
    else return CLS_NORM;
  endfunction

  // Final {flags, value}: override for special classes, core result otherwise.
  function automatic logic [34:0] resolve(input cls_t cls, input logic sgn,
                                          input logic [31:0] c);
    case (cls)
      CLS_NAN:  return {3'b100, 32'h7FC0_0000};
      CLS_INF:  return {3'b010, sgn, 8'hFF, 23'h0};
      CLS_ZERO: return {3'b001, sgn, 31'h0};
      default:  return {1'b0, (c[30:23] == 8'hFF), (c[30:23] == 8'h00), c};
    endcase
  endfunction

  logic [MUL_LAT:0] vld_p;
  cls_t             cls_p [0:MUL_LAT];
  logic [MUL_LAT:0] sgn_p;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    fifo_count;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [31:0]      mem_c [DEPTH];
  logic [2:0]       mem_f [DEPTH];
  logic             rdy_en;
  logic             accept;
  logic             wr;
  logic             pop;
  logic [34:0]      wr_data;
  logic [CW-1:0]    outstanding;

  assign accept      = in_valid && in_ready;
  assign wr          = vld_p[MUL_LAT];
  assign pop         = out_valid && out_ready;
  assign outstanding = fifo_count + inflight;
  // Current-cycle counts only: a same-cycle pop does not return its credit yet.
  assign in_ready    = rdy_en && (outstanding < CW'(DEPTH));
  assign out_valid   = (fifo_count != '0);
  assign out_c       = out_valid ? mem_c[rd_ptr] : '0;
  assign out_flags   = out_valid ? mem_f[rd_ptr] : '0;
  assign busy        = (inflight != '0) || (fifo_count != '0);
  assign wr_data     = resolve(cls_p[MUL_LAT], sgn_p[MUL_LAT], mul_c);

  // Control state: valid pipe, credit counters, FIFO pointers, operand latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p      <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rdy_en     <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
    end else begin
      rdy_en     <= 1'b1;
      // Stage 0 .. MUL_LAT: valid bit follows the operands through the core
      vld_p      <= {vld_p[MUL_LAT-1:0], accept};
      inflight   <= inflight + CW'(accept) - CW'(wr);
      fifo_count <= fifo_count + CW'(wr) - CW'(pop);
      if (wr)  wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (accept) begin
        mul_a <= in_a;
        mul_b <= in_b;
      end
    end
  end

  // Tag payload and FIFO storage; qualified by the valid pipe, so no reset.
  always_ff @(posedge clk) begin
    cls_p[0] <= classify(in_a, in_b);
    sgn_p    <= {sgn_p[MUL_LAT-1:0], in_a[31] ^ in_b[31]};
    for (int i = 1; i <= MUL_LAT; i++) cls_p[i] <= cls_p[i-1];
    // Stage MUL_LAT+1: resolved result enters the FIFO
    if (wr) begin
      mem_c[wr_ptr] <= wr_data[31:0];
      mem_f[wr_ptr] <= wr_data[34:32];
    end
  end

endmodule
